// File: rtl/ic_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ic_ram_port_arbiter
//
// Shares the single RAM target port between the CPU instruction-fetch (imem)
// and data (dmem) requesters. Requests use a req/gnt channel and responses a
// recv/ack channel. An owner FIFO records who issued each accepted request,
// so responses are steered back, in order, to the requester that issued them.
//
// Optional build macro: SCARV_IC_ARB_ROUND_ROBIN_EN
//   defined   - when both requesters ask at once, the one not granted last
//               wins (dmem wins the first tie after reset).
//   undefined - when both ask at once, dmem always wins.
//
// Ports:
//   g_clk, g_resetn          clock, asynchronous active-low reset
//   imem_* / dmem_*          requester channels: req, wen, strb, wdata, addr
//                            in; gnt, recv, error, rdata out; ack in
//   tgt_req/wen/strb/wdata/addr   request to RAM (out), tgt_gnt (in)
//   tgt_recv/error/rdata     RAM response (in), tgt_ack (out)
//   stray_rsp                sticky: a response arrived with nothing
//                            outstanding; cleared only by reset
// ---------------------------------------------------------------------------
module ic_ram_port_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int OWNER_W     = 1
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        imem_req,
    input  logic        imem_wen,
    input  logic [3:0]  imem_strb,
    input  logic [31:0] imem_wdata,
    input  logic [31:0] imem_addr,
    output logic        imem_gnt,
    output logic        imem_recv,
    input  logic        imem_ack,
    output logic        imem_error,
    output logic [31:0] imem_rdata,

    input  logic        dmem_req,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_strb,
    input  logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_addr,
    output logic        dmem_gnt,
    output logic        dmem_recv,
    input  logic        dmem_ack,
    output logic        dmem_error,
    output logic [31:0] dmem_rdata,

    output logic        tgt_req,
    output logic        tgt_wen,
    output logic [3:0]  tgt_strb,
    output logic [31:0] tgt_wdata,
    output logic [31:0] tgt_addr,
    input  logic        tgt_gnt,
    input  logic        tgt_recv,
    input  logic        tgt_error,
    input  logic [31:0] tgt_rdata,
    output logic        tgt_ack,

    output logic        stray_rsp
);

    // A single-entry FIFO still needs a 1-bit pointer; wrap is explicit.
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING) + 1;

    localparam logic [OWNER_W-1:0] OWN_IMEM = '0;
    localparam logic [OWNER_W-1:0] OWN_DMEM = OWNER_W'(1);

    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(OUTSTANDING - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    logic [CW-1:0]      r_count;
    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic               r_lock;
    logic               r_lock_sel;     // 1 = dmem
    logic               r_stray;
    logic [OWNER_W-1:0] r_owner [OUTSTANDING];

    logic               w_tie_winner;   // 1 = dmem
    logic               w_sel;          // 1 = dmem
    logic               w_sel_req;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_head_dmem;

`ifdef SCARV_IC_ARB_ROUND_ROBIN_EN
    logic               r_last_dmem;    // reset as "imem was last"

    assign w_tie_winner = ~r_last_dmem;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_last_dmem <= 1'b0;
        end else if (w_push) begin
            r_last_dmem <= w_sel;
        end
    end
`else
    assign w_tie_winner = 1'b1;
`endif

    assign w_full  = (r_count == CW'(OUTSTANDING));
    assign w_empty = (r_count == '0);

    // While a request is stalled the selection is frozen, so the payload on
    // the target port cannot change under the RAM mid-handshake.
    always_comb begin
        w_sel = 1'b0;
        if (r_lock) begin
            w_sel = r_lock_sel;
        end else if (imem_req && dmem_req) begin
            w_sel = w_tie_winner;
        end else if (dmem_req) begin
            w_sel = 1'b1;
        end
    end

    assign w_sel_req = w_sel ? dmem_req : imem_req;

    assign tgt_req   = w_sel_req & ~w_full;
    assign tgt_wen   = w_sel ? dmem_wen   : imem_wen;
    assign tgt_strb  = w_sel ? dmem_strb  : imem_strb;
    assign tgt_wdata = w_sel ? dmem_wdata : imem_wdata;
    assign tgt_addr  = w_sel ? dmem_addr  : imem_addr;

    assign w_push   = tgt_req & tgt_gnt;
    assign imem_gnt = w_push & ~w_sel;
    assign dmem_gnt = w_push &  w_sel;

    // Any non-imem owner code is treated as dmem; the head entry is only
    // meaningful while the FIFO is non-empty.
    assign w_head_dmem = (r_owner[r_head] != OWN_IMEM);

    assign imem_recv  = tgt_recv & ~w_empty & ~w_head_dmem;
    assign dmem_recv  = tgt_recv & ~w_empty &  w_head_dmem;
    assign tgt_ack    = ~w_empty & (w_head_dmem ? dmem_ack : imem_ack);
    assign w_pop      = tgt_recv & tgt_ack;

    assign imem_error = tgt_error;
    assign dmem_error = tgt_error;
    assign imem_rdata = tgt_rdata;
    assign dmem_rdata = tgt_rdata;

    assign stray_rsp  = r_stray;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_lock     <= 1'b0;
            r_lock_sel <= 1'b0;
            r_stray    <= 1'b0;
        end else begin
            // Lock holds exactly while a request is presented but not taken.
            r_lock     <= tgt_req & ~tgt_gnt;
            r_lock_sel <= w_sel;

            if (w_push) begin
                r_tail <= f_ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= f_ptr_inc(r_head);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (tgt_recv && w_empty) begin
                r_stray <= 1'b1;
            end
        end
    end

    // Owner storage holds data only; validity is tracked by r_count.
    always_ff @(posedge g_clk) begin
        if (w_push) begin
            r_owner[r_tail] <= w_sel ? OWN_DMEM : OWN_IMEM;
        end
    end

endmodule

// File: tb/tb_ic_ram_port_arbiter.sv
module tb_ic_ram_port_arbiter;

    localparam int OUT = 2;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        imem_req, imem_wen, imem_ack;
    logic [3:0]  imem_strb;
    logic [31:0] imem_wdata, imem_addr;
    logic        imem_gnt, imem_recv, imem_error;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_wen, dmem_ack;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_wdata, dmem_addr;
    logic        dmem_gnt, dmem_recv, dmem_error;
    logic [31:0] dmem_rdata;
    logic        tgt_req, tgt_wen, tgt_gnt, tgt_recv, tgt_error, tgt_ack;
    logic [3:0]  tgt_strb;
    logic [31:0] tgt_wdata, tgt_addr, tgt_rdata;
    logic        stray_rsp;

    int errors = 0;
    int checks = 0;

    always #5 g_clk = ~g_clk;

    ic_ram_port_arbiter #(.OUTSTANDING(OUT), .OWNER_W(1)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .imem_req(imem_req), .imem_wen(imem_wen), .imem_strb(imem_strb),
        .imem_wdata(imem_wdata), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_error(imem_error),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
        .dmem_wdata(dmem_wdata), .dmem_addr(dmem_addr), .dmem_gnt(dmem_gnt),
        .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
        .dmem_rdata(dmem_rdata),
        .tgt_req(tgt_req), .tgt_wen(tgt_wen), .tgt_strb(tgt_strb),
        .tgt_wdata(tgt_wdata), .tgt_addr(tgt_addr), .tgt_gnt(tgt_gnt),
        .tgt_recv(tgt_recv), .tgt_error(tgt_error), .tgt_rdata(tgt_rdata),
        .tgt_ack(tgt_ack), .stray_rsp(stray_rsp)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_q holds owners of accepted-but-unanswered requests (0 imem, 1 dmem).
    // m_held is the requester whose request is on the port but not yet taken.
    int m_q[$];
    int m_held  = -1;
    int m_last  = 0;
    bit m_stray = 0;
    int m_sel, m_head;
    bit m_full, m_empty, m_sel_req, m_treq, m_push, m_ack, m_pop;

    function automatic int tie_winner(input int last);
`ifdef SCARV_IC_ARB_ROUND_ROBIN_EN
        return (last == 1) ? 0 : 1;
`else
        return 1;
`endif
    endfunction

    initial begin
        forever begin
            @(negedge g_clk);
            #2;
            if (!g_resetn) begin
                m_q.delete(); m_held = -1; m_last = 0; m_stray = 0;
            end
            m_full  = (m_q.size() >= OUT);
            m_empty = (m_q.size() == 0);
            if (m_held >= 0)                m_sel = m_held;
            else if (imem_req && dmem_req)  m_sel = tie_winner(m_last);
            else if (dmem_req)              m_sel = 1;
            else if (imem_req)              m_sel = 0;
            else                            m_sel = -1;
            m_sel_req = (m_sel == 1) ? dmem_req : ((m_sel == 0) ? imem_req : 1'b0);
            m_treq    = m_sel_req && !m_full;
            m_push    = m_treq && tgt_gnt;
            m_head    = m_empty ? -1 : m_q[0];
            m_ack     = (m_head == 0 && imem_ack) || (m_head == 1 && dmem_ack);
            m_pop     = tgt_recv && m_ack;

            chk("tgt_req",   tgt_req,   m_treq);
            chk("imem_gnt",  imem_gnt,  m_push && m_sel == 0);
            chk("dmem_gnt",  dmem_gnt,  m_push && m_sel == 1);
            chk("imem_recv", imem_recv, tgt_recv && m_head == 0);
            chk("dmem_recv", dmem_recv, tgt_recv && m_head == 1);
            chk("tgt_ack",   tgt_ack,   m_ack);
            chk("stray_rsp", stray_rsp, m_stray);
            chk("imem_rdata", imem_rdata, tgt_rdata);
            chk("dmem_rdata", dmem_rdata, tgt_rdata);
            chk("imem_error", imem_error, tgt_error);
            chk("dmem_error", dmem_error, tgt_error);
            if (m_treq) begin
                chk("tgt_addr",  tgt_addr,  (m_sel == 1) ? dmem_addr  : imem_addr);
                chk("tgt_wdata", tgt_wdata, (m_sel == 1) ? dmem_wdata : imem_wdata);
                chk("tgt_strb",  tgt_strb,  (m_sel == 1) ? dmem_strb  : imem_strb);
                chk("tgt_wen",   tgt_wen,   (m_sel == 1) ? dmem_wen   : imem_wen);
            end

            @(posedge g_clk);
            #1;
            if (!g_resetn) begin
                m_q.delete(); m_held = -1; m_last = 0; m_stray = 0;
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_push) begin
                    m_q.push_back(m_sel);
                    m_last = m_sel;
                end
                m_held = (m_treq && !tgt_gnt) ? m_sel : -1;
                if (tgt_recv && m_empty) m_stray = 1;
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        g_resetn = 0;
        imem_req = 0; imem_wen = 0; imem_strb = 4'h0; imem_wdata = '0; imem_addr = '0; imem_ack = 0;
        dmem_req = 0; dmem_wen = 0; dmem_strb = 4'h0; dmem_wdata = '0; dmem_addr = '0; dmem_ack = 0;
        tgt_gnt = 0; tgt_recv = 0; tgt_error = 0; tgt_rdata = '0;

        @(negedge g_clk); #3;
        chk("rst_tgt_req", tgt_req, 0);
        chk("rst_stray", stray_rsp, 0);
        chk("rst_tgt_ack", tgt_ack, 0);

        // T1: imem read granted same cycle
        @(negedge g_clk);
        g_resetn = 1;
        imem_req = 1; imem_addr = 32'h0000_0010; tgt_gnt = 1;
        #3;
        chk("t1_imem_gnt", imem_gnt, 1);
        chk("t1_addr", tgt_addr, 32'h0000_0010);

        // T2: response to imem
        @(negedge g_clk);
        imem_req = 0; tgt_gnt = 0; tgt_recv = 1; tgt_rdata = 32'hDEAD_BEEF; imem_ack = 1;
        #3;
        chk("t2_imem_recv", imem_recv, 1);
        chk("t2_imem_rdata", imem_rdata, 32'hDEAD_BEEF);
        chk("t2_dmem_recv", dmem_recv, 0);
        chk("t2_tgt_ack", tgt_ack, 1);

        // T3: tie -> dmem first
        @(negedge g_clk);
        tgt_recv = 0; imem_ack = 0;
        imem_req = 1; imem_addr = 32'h100;
        dmem_req = 1; dmem_addr = 32'h200; dmem_wen = 1; dmem_wdata = 32'h1234; dmem_strb = 4'hF;
        tgt_gnt = 1;
        #3;
        chk("t3_dmem_gnt", dmem_gnt, 1);
        chk("t3_imem_gnt", imem_gnt, 0);
        chk("t3_addr", tgt_addr, 32'h200);
        chk("t3_wen", tgt_wen, 1);

        // T4: imem alone next
        @(negedge g_clk);
        dmem_req = 0; dmem_wen = 0;
        #3;
        chk("t4_imem_gnt", imem_gnt, 1);

        // T5/T6: responses return dmem then imem
        @(negedge g_clk);
        imem_req = 0; tgt_gnt = 0;
        tgt_recv = 1; tgt_rdata = 32'hAAAA_0001; imem_ack = 1; dmem_ack = 1;
        #3;
        chk("t5_dmem_recv", dmem_recv, 1);
        chk("t5_imem_recv", imem_recv, 0);

        @(negedge g_clk);
        tgt_rdata = 32'hBBBB_0002; tgt_error = 1;
        #3;
        chk("t6_imem_recv", imem_recv, 1);
        chk("t6_imem_error", imem_error, 1);
        chk("t6_dmem_recv", dmem_recv, 0);

        // T7-T10: lock holds imem while dmem arrives
        @(negedge g_clk);
        tgt_recv = 0; tgt_error = 0; imem_ack = 0; dmem_ack = 0;
        imem_req = 1; imem_addr = 32'h300; tgt_gnt = 0;
        #3;
        chk("t7_addr", tgt_addr, 32'h300);
        chk("t7_imem_gnt", imem_gnt, 0);

        @(negedge g_clk);
        dmem_req = 1; dmem_addr = 32'h400;
        #3;
        chk("t8_addr", tgt_addr, 32'h300);
        chk("t8_dmem_gnt", dmem_gnt, 0);

        @(negedge g_clk);
        #3;
        chk("t9_addr", tgt_addr, 32'h300);

        @(negedge g_clk);
        tgt_gnt = 1;
        #3;
        chk("t10_imem_gnt", imem_gnt, 1);
        chk("t10_dmem_gnt", dmem_gnt, 0);

        @(negedge g_clk);
        imem_req = 0;
        #3;
        chk("t11_dmem_gnt", dmem_gnt, 1);
        chk("t11_addr", tgt_addr, 32'h400);

        // T12: FIFO full blocks a third request
        @(negedge g_clk);
        dmem_req = 0; imem_req = 1; imem_addr = 32'h500;
        #3;
        chk("t12_full_gnt", imem_gnt, 0);
        chk("t12_full_req", tgt_req, 0);

        // T13/T14: response held by owner ack=0
        @(negedge g_clk);
        tgt_recv = 1; tgt_rdata = 32'hCCCC_0003; imem_ack = 0;
        #3;
        chk("t13_imem_recv", imem_recv, 1);
        chk("t13_tgt_ack", tgt_ack, 0);

        @(negedge g_clk);
        #3;
        chk("t14_tgt_ack", tgt_ack, 0);
        chk("t14_full_req", tgt_req, 0);

        // T15: pop; full still judged on registered count
        @(negedge g_clk);
        imem_ack = 1;
        #3;
        chk("t15_tgt_ack", tgt_ack, 1);
        chk("t15_imem_gnt", imem_gnt, 0);

        // T16: third request granted after the pop
        @(negedge g_clk);
        tgt_recv = 0; imem_ack = 0;
        #3;
        chk("t16_imem_gnt", imem_gnt, 1);
        chk("t16_addr", tgt_addr, 32'h500);

        // T17/T18: drain dmem then imem
        @(negedge g_clk);
        imem_req = 0; tgt_gnt = 0;
        tgt_recv = 1; imem_ack = 1; dmem_ack = 1;
        #3;
        chk("t17_dmem_recv", dmem_recv, 1);

        @(negedge g_clk);
        #3;
        chk("t18_imem_recv", imem_recv, 1);

        // T19: response with empty FIFO
        @(negedge g_clk);
        #3;
        chk("t19_imem_recv", imem_recv, 0);
        chk("t19_dmem_recv", dmem_recv, 0);
        chk("t19_tgt_ack", tgt_ack, 0);

        // T20: sticky flag, then async clear
        @(negedge g_clk);
        tgt_recv = 0;
        #3;
        chk("t20_stray", stray_rsp, 1);
        g_resetn = 0;
        #1;
        chk("t20_stray_async_clr", stray_rsp, 0);

        // T22/T23: reset in the middle of outstanding traffic
        @(negedge g_clk);
        g_resetn = 1; imem_ack = 0; dmem_ack = 0;
        imem_req = 1; imem_addr = 32'h600; tgt_gnt = 1;
        #3;
        chk("t22_imem_gnt", imem_gnt, 1);

        @(negedge g_clk);
        imem_req = 0; dmem_req = 1; dmem_addr = 32'h700; tgt_gnt = 0;
        #3;
        g_resetn = 0;
        #1;
        chk("t23_rst_stray", stray_rsp, 0);

        @(negedge g_clk);
        g_resetn = 1; dmem_req = 0;
        tgt_recv = 1; imem_ack = 1;
        #3;
        chk("t24_imem_recv", imem_recv, 0);
        chk("t24_tgt_ack", tgt_ack, 0);

        @(negedge g_clk);
        tgt_recv = 0; imem_ack = 0;
        #3;
        chk("t25_stray", stray_rsp, 1);

        @(negedge g_clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ic_ram_port_arbiter.md
Name: ic_ram_port_arbiter

Overview:
Shares the single RAM target port of the interconnect between the CPU instruction fetch (imem) and data (dmem) requesters. All three ports use the req/gnt request channel and recv/ack response channel.
Tracks outstanding transactions in an owner FIFO so responses return, in order, to the requester that issued them.
Sits between the ic_top request decode and the RAM.

Parameters:
OUTSTANDING, 2, maximum accepted-but-unresponded transactions on the target port (power of two, 1..8).
OWNER_W, 1, width of a FIFO owner entry (0 = imem, 1 = dmem).

Ports:
g_clk  input  1  global clock
g_resetn  input  1  asynchronous active-low reset
imem_req / dmem_req  input  1  request valid
imem_wen / dmem_wen  input  1  write enable
imem_strb / dmem_strb  input  4  write strobe
imem_wdata / dmem_wdata  input  32  write data
imem_addr / dmem_addr  input  32  address
imem_gnt / dmem_gnt  output  1  request accepted
imem_recv / dmem_recv  output  1  response valid
imem_ack / dmem_ack  input  1  requester accepts response
imem_error / dmem_error  output  1  response error
imem_rdata / dmem_rdata  output  32  read data
tgt_req, tgt_wen  output  1,1  request to RAM
tgt_strb, tgt_wdata, tgt_addr  output  4,32,32  request payload to RAM
tgt_gnt  input  1  RAM accepted request
tgt_recv, tgt_error  input  1,1  RAM response valid / error
tgt_rdata  input  32  RAM read data
tgt_ack  output  1  response accepted by owning requester
stray_rsp  output  1  sticky flag: response arrived with owner FIFO empty

Behaviour:
- Clocking: one clock, g_clk. Reset is asynchronous and active-low on g_resetn.
- Reset state: FIFO count 0, lock clear, stray_rsp 0. With the FIFO empty, all gnt, recv and tgt_ack outputs are 0.
- Selection:
  - Neither requester asserts req: no selection, tgt_req = 0.
  - Only one asserts req: that requester is selected.
  - Both assert req: fixed priority, dmem wins.
- Lock: once a requester is selected and tgt_req is high without tgt_gnt, the selection is registered and held until the handshake completes. No switching mid-request, even if the other requester raises req. Lock clears on the cycle tgt_req & tgt_gnt.
- Request path (combinational):
  - tgt_req = selected req & !full.
  - tgt_wen/strb/wdata/addr are muxed from the selected requester.
  - Selected gnt = tgt_gnt & tgt_req. Non-selected gnt = 0.
  - Zero added latency.
- Push: on tgt_req & tgt_gnt, write the owner ID at the FIFO tail and increment count.
- Response path (combinational from FIFO head):
  - head owner's recv = tgt_recv & !empty. Other requester's recv = 0.
  - error and rdata are forwarded to both requesters; only the owner's recv qualifies them.
  - tgt_ack = head owner's ack & !empty.
- Pop: on tgt_recv & tgt_ack, advance the head and decrement count.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full (count == OUTSTANDING): tgt_req is forced 0 and no gnt is issued, even if a pop occurs in the same cycle. Full is evaluated on the registered count.
- Empty with tgt_recv: tgt_ack = 0, no recv to either requester, stray_rsp set. stray_rsp clears only on reset.
- Pointers wrap modulo OUTSTANDING. count has width clog2(OUTSTANDING)+1.
- Reset asserted mid-transaction: FIFO and lock clear immediately. Any later response is treated as stray.

Optional Feature:
SCARV_IC_ARB_ROUND_ROBIN_EN
- Defined: the both-requesting tie-break uses a 1-bit last-winner register (reset value: imem was last, so dmem wins the first tie). Winner = requester not granted last. The register updates on each tgt_req & tgt_gnt.
- Undefined: fixed dmem priority as above, and the register is absent.

Test Plan:
- Reset, then imem read at addr 0x0000_0010 with tgt_gnt=1 → imem_gnt=1 same cycle. On tgt_recv with rdata 0xDEAD_BEEF: imem_recv=1, imem_rdata=0xDEAD_BEEF, dmem_recv=0.
- imem and dmem both assert req in the same cycle, tgt_gnt=1 → dmem granted first (round-robin build: dmem, then imem on the next tie). Responses return dmem then imem, in order.
- imem req with tgt_gnt=0 for 3 cycles, dmem raises req in cycle 2 → tgt_addr stays at imem_addr until the grant. dmem is granted only after that.
- OUTSTANDING=2: two grants with no response → third req gets gnt=0 and tgt_req=0. The third is granted in the cycle after the first pop.
- Response held with owner ack=0 for 2 cycles → tgt_ack=0 and the FIFO does not pop. ack=1 → pop occurs and count decrements.
- tgt_recv=1 with an empty FIFO → stray_rsp=1, no recv to either requester, tgt_ack=0. Apply g_resetn=0 → stray_rsp=0 asynchronously.
